hazard_unit: RTL
================

# hazard_unit

Pipeline hazard and stall generator for the five-stage MIPS core. It sits beside the pipeline controller and datapath and produces every stall and flush input the controller's D/E/M/W control registers consume. It also produces the forwarding selects for the datapath. A small FSM sequences multi-cycle divides: it launches the external divider and holds the front of the pipe until the divider reports completion.

## Interface
- No parameters; register-number width fixed at 5, HI/LO forwarding select fixed at 2 bits.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rsD, rtD  in  5  source registers of the instruction in D
- rsE, rtE  in  5  source registers of the instruction in E
- writeregE, writeregM, writeregW  in  5  destination register per stage
- regwriteE, regwriteM, regwriteW  in  1  register-write enable per stage
- memtoregE, memtoregM  in  1  load in E / M
- branchD  in  1  branch in D (compare resolved in D)
- write_hiloM, write_hiloW  in  1  HI/LO write in M / W
- divE  in  1  divide instruction in E
- div_done  in  1  divider result valid, one-cycle pulse
- div_start  out  1  one-cycle divider launch pulse
- forwardAD, forwardBD  out  1  D-stage compare operand from M ALU result
- forwardAE, forwardBE  out  2  E operand select: 00 regfile, 10 from M, 01 from W
- forward_hiloE  out  2  00 HI/LO reg, 01 from M, 10 from W
- stallF, stallD, stallE, stallM, stallW  out  1  stage hold
- flushD, flushE, flushM, flushW  out  1  stage clear

## Operation
- Register 0 never matches; every match term requires a nonzero register number.
- forwardAE: 10 if regwriteM and writeregM==rsE; else 01 if regwriteW and writeregW==rsE; else 00. M wins over W. forwardBE uses the same rule with rtE.
- forwardAD = regwriteM and writeregM==rsD. forwardBD uses the same rule with rtD.
- forward_hiloE = 01 if write_hiloM; else 10 if write_hiloW; else 00.
- lwstall = memtoregE and regwriteE and writeregE in {rsD, rtD}.
- branchstall = branchD and either of:
  - regwriteE and writeregE in {rsD, rtD}
  - memtoregM and writeregM in {rsD, rtD}
- Divide FSM, states IDLE, BUSY, DONE:
  - IDLE: if divE, assert div_start and move to BUSY; otherwise stay in IDLE.
  - BUSY: on div_done move to DONE; otherwise stay in BUSY.
  - DONE: move unconditionally to IDLE.
  - DONE exists so that divE, still high while the divide leaves E, cannot relaunch it.
- divstall = (IDLE and divE) or BUSY. It is low in DONE.
- Output equations:
  - stallF = stallD = lwstall or branchstall or divstall
  - stallE = divstall
  - flushE = (lwstall or branchstall) and not divstall
  - stallM = stallW = 0
  - flushD = flushM = flushW = rst

## Timing
- Forwarding, stall and flush outputs are combinational from the current inputs and FSM state, valid in the same cycle.
- div_start is combinational and asserted only in the first cycle a divide is in E.
- div_done is ignored outside BUSY.
- A div_done arriving one cycle after div_start is legal: BUSY lasts 1 cycle, DONE 1 cycle.
- Divide cost = N+1 stall cycles for a divider latency of N cycles from start to done.
- Back-to-back divides: the second divE is seen in IDLE the cycle after DONE and launches normally.
- lwstall or branchstall during BUSY: F/D stay held, and flushE is suppressed because E is held.
- Reset values, applied while rst is high and on the first edge:
  - FSM in IDLE; div_start=0
  - all stalls 0
  - flushD, flushE, flushM, flushW = 1
  - forwarding outputs 00/0 (rst gates them)
- Reset during BUSY: the FSM returns to IDLE on that edge, and no div_start is issued while rst is high.

## Test plan
- Load-use: memtoregE=1, regwriteE=1, writeregE=8, rsD=8 -> stallF=stallD=1, flushE=1, stallE=0. Repeat with writeregE=0 -> no stall.
- Forward priority: regwriteM=1, writeregM=5, regwriteW=1, writeregW=5, rsE=5 -> forwardAE=10. Drop regwriteM -> forwardAE=01.
- Branch hazards:
  - branchD=1, regwriteE=1, writeregE=rtD=3 -> branchstall (stallD=1, flushE=1).
  - memtoregM=1, writeregM=3 with regwriteE=0 -> branchstall still asserted.
- Divide, latency 4: divE=1 at cycle 0 -> div_start=1 at cycle 0 only; stallF/D/E=1 cycles 0–4; div_done at cycle 4 -> cycle 5 in DONE with stalls 0; no second div_start.
- Reset mid-divide: rst=1 during BUSY -> next cycle IDLE, all flushes 1, stalls 0. With divE still high after rst drops, exactly one new div_start.
- HI/LO: write_hiloM=1 and write_hiloW=1 -> forward_hiloE=01. Only write_hiloW=1 -> 10.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-state inputs and stall/flush/forward outputs exchanged
// between the hazard unit (slave) and the pipeline controller/datapath (master).
interface hazard_unit_if;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM;
  logic       branchD;
  logic       write_hiloM, write_hiloW;
  logic       divE;
  logic       div_done;

  logic       div_start;
  logic       forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic [1:0] forward_hiloE;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushD, flushE, flushM, flushW;

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, write_hiloM, write_hiloW, divE, div_done,
    output div_start, forwardAD, forwardBD, forwardAE, forwardBE, forward_hiloE,
           stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW
  );

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, write_hiloM, write_hiloW, divE, div_done,
    input  div_start, forwardAD, forwardBD, forwardAE, forwardBE, forward_hiloE,
           stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection, forwarding selects and divide sequencing for the
// five-stage MIPS pipeline. All hazard outputs are combinational.
module hazard_unit (
  input logic           clk,
  input logic           rst,
  hazard_unit_if.slave  hz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

  divState_t divState;
  logic      lwstall;
  logic      branchstall;
  logic      divstall;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // DONE absorbs the cycle in which divE is still high as the divide leaves E.
  always_ff @(posedge clk) begin
    if (rst) begin
      divState <= IDLE;
    end else begin
      case (divState)
        IDLE:    if (hz.divE) divState <= BUSY;
        BUSY:    if (hz.div_done) divState <= DONE;
        DONE:    divState <= IDLE;
        default: divState <= IDLE;
      endcase
    end
  end

  always_comb begin
    lwstall          = 1'b0;
    branchstall      = 1'b0;
    divstall         = 1'b0;
    hz.div_start     = 1'b0;
    hz.forwardAE     = 2'b00;
    hz.forwardBE     = 2'b00;
    hz.forwardAD     = 1'b0;
    hz.forwardBD     = 1'b0;
    hz.forward_hiloE = 2'b00;

    if (!rst) begin
      if (hz.regwriteM && regMatch(hz.writeregM, hz.rsE))      hz.forwardAE = 2'b10;
      else if (hz.regwriteW && regMatch(hz.writeregW, hz.rsE)) hz.forwardAE = 2'b01;

      if (hz.regwriteM && regMatch(hz.writeregM, hz.rtE))      hz.forwardBE = 2'b10;
      else if (hz.regwriteW && regMatch(hz.writeregW, hz.rtE)) hz.forwardBE = 2'b01;

      hz.forwardAD = hz.regwriteM && regMatch(hz.writeregM, hz.rsD);
      hz.forwardBD = hz.regwriteM && regMatch(hz.writeregM, hz.rtD);

      if (hz.write_hiloM)      hz.forward_hiloE = 2'b01;
      else if (hz.write_hiloW) hz.forward_hiloE = 2'b10;

      lwstall = hz.memtoregE && hz.regwriteE &&
                (regMatch(hz.writeregE, hz.rsD) || regMatch(hz.writeregE, hz.rtD));

      branchstall = hz.branchD &&
        ((hz.regwriteE && (regMatch(hz.writeregE, hz.rsD) || regMatch(hz.writeregE, hz.rtD))) ||
         (hz.memtoregM && (regMatch(hz.writeregM, hz.rsD) || regMatch(hz.writeregM, hz.rtD))));

      hz.div_start = (divState == IDLE) && hz.divE;
      divstall     = ((divState == IDLE) && hz.divE) || (divState == BUSY);
    end
  end

  // E is frozen during a divide, so clearing it then would lose the divide.
  assign hz.stallF = lwstall || branchstall || divstall;
  assign hz.stallD = lwstall || branchstall || divstall;
  assign hz.stallE = divstall;
  assign hz.stallM = 1'b0;
  assign hz.stallW = 1'b0;
  assign hz.flushD = rst;
  assign hz.flushE = rst || ((lwstall || branchstall) && !divstall);
  assign hz.flushM = rst;
  assign hz.flushW = rst;

endmodule
